// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout reads always win, a clear engine and a
// pixel writer share the leftover cycles (optionally only during vertical blanking).
module fb_port_arbiter #(
   parameter int          DEPTH     = 76800,
   parameter int          ADDR_W    = 17,
   parameter int          DATA_W    = 4,
   parameter int          CLEAR_VAL = 0,
   parameter bit          TEAR_FREE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_en,
   input  logic [ADDR_W-1:0] vid_addr,
   input  logic              vblank,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_rvalid,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              vid_rvalid_q, vid_rvalid_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic              win;
   logic              wr_in_range;
   logic              clr_grant;

   assign win         = TEAR_FREE ? vblank : 1'b1;
   // Widened compare so DEPTH == 2**ADDR_W still works.
   assign wr_in_range = (32'(wr_addr) < 32'(DEPTH));

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = vid_addr;
      ram_wdata = wr_data;
      wr_ready  = 1'b0;
      clr_grant = 1'b0;
      if (!reset) begin
         wr_ready = !vid_en && win && (state_q == ST_IDLE);
         if (vid_en) begin
            ram_en = 1'b1;
         end else if ((state_q == ST_CLEAR) && win) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr_q;
            ram_wdata = DATA_W'(CLEAR_VAL);
            clr_grant = 1'b1;
         end else if ((state_q == ST_IDLE) && win && wr_valid) begin
            // Out-of-range writes are handshaken but never reach the RAM.
            ram_en   = wr_in_range;
            ram_we   = wr_in_range;
            ram_addr = wr_addr;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      vid_rvalid_d = vid_en;
      stall_cnt_d  = stall_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            if (clr_grant) begin
               if (clr_addr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
               end else begin
                  clr_addr_d = clr_addr_q + ADDR_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         clr_addr_q   <= '0;
         vid_rvalid_q <= 1'b0;
         stall_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         vid_rvalid_q <= vid_rvalid_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign vid_rdata  = ram_rdata;
   assign vid_rvalid = vid_rvalid_q;
   assign clr_busy   = (state_q != ST_IDLE);
   assign clr_done   = (state_q == ST_DONE);
   assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: one instance with free access, one restricted
// to vertical blanking, both with a 16-word framebuffer.
module tb_fb_port_arbiter;

   localparam int DEPTH = 16;
   localparam int AW    = 8;
   localparam int DW    = 4;
   localparam logic [DW-1:0] CV = 4'h5;

   logic          clk = 1'b0;
   logic          reset;
   logic          vid_en, vblank, wr_valid, clr_start;
   logic [AW-1:0] vid_addr, wr_addr, ram_addr;
   logic [DW-1:0] wr_data, ram_rdata, vid_rdata, ram_wdata;
   logic          vid_rvalid, wr_ready, clr_busy, clr_done, ram_en, ram_we;
   logic [15:0]   stall_cnt;

   logic          t_vid_en, t_vblank, t_wr_valid, t_clr_start;
   logic [AW-1:0] t_vid_addr, t_wr_addr, t_ram_addr;
   logic [DW-1:0] t_wr_data, t_ram_rdata, t_vid_rdata, t_ram_wdata;
   logic          t_vid_rvalid, t_wr_ready, t_clr_busy, t_clr_done, t_ram_en, t_ram_we;
   logic [15:0]   t_stall_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fb_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(5), .TEAR_FREE(1'b0)) dut (
      .clk(clk), .reset(reset), .vid_en(vid_en), .vid_addr(vid_addr), .vblank(vblank),
      .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start), .clr_busy(clr_busy),
      .clr_done(clr_done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
   );

   fb_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(5), .TEAR_FREE(1'b1)) dut_tf (
      .clk(clk), .reset(reset), .vid_en(t_vid_en), .vid_addr(t_vid_addr), .vblank(t_vblank),
      .vid_rdata(t_vid_rdata), .vid_rvalid(t_vid_rvalid), .wr_valid(t_wr_valid), .wr_ready(t_wr_ready),
      .wr_addr(t_wr_addr), .wr_data(t_wr_data), .clr_start(t_clr_start), .clr_busy(t_clr_busy),
      .clr_done(t_clr_done), .ram_en(t_ram_en), .ram_we(t_ram_we), .ram_addr(t_ram_addr),
      .ram_wdata(t_ram_wdata), .ram_rdata(t_ram_rdata), .stall_cnt(t_stall_cnt)
   );

   task automatic test_reset();
      reset = 1'b1;
      vid_en = 1'b1; vid_addr = 8'd2; vblank = 1'b0; wr_valid = 1'b1; wr_addr = 8'd1;
      wr_data = 4'h1; clr_start = 1'b0; ram_rdata = 4'h0;
      t_vid_en = 1'b0; t_vid_addr = '0; t_vblank = 1'b0; t_wr_valid = 1'b0; t_wr_addr = '0;
      t_wr_data = '0; t_clr_start = 1'b0; t_ram_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b0 || ram_we !== 1'b0 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_port: ram_en=%b ram_we=%b wr_ready=%b, required all 0", ram_en, ram_we, wr_ready);
      end
      checks++;
      if (vid_rvalid !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: rvalid=%b busy=%b done=%b stall=%0d, required 0/0/0/0",
                  vid_rvalid, clr_busy, clr_done, stall_cnt);
      end
      vid_en = 1'b0; wr_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_scanout();
      vid_en = 1'b1; vid_addr = 8'd5; wr_valid = 1'b1; wr_addr = 8'd9; ram_rdata = 4'h9;
      #1;
      checks++;
      if (wr_ready !== 1'b0 || ram_we !== 1'b0 || ram_en !== 1'b1 || ram_addr !== 8'd5) begin
         errors++;
         $display("FAIL scanout_grant: wr_ready=%b ram_we=%b ram_en=%b ram_addr=%0d, required 0/0/1/5",
                  wr_ready, ram_we, ram_en, ram_addr);
      end
      checks++;
      if (vid_rvalid !== 1'b0 || vid_rdata !== 4'h9) begin
         errors++;
         $display("FAIL scanout_pre: rvalid=%b rdata=%h, required 0/9", vid_rvalid, vid_rdata);
      end
      @(negedge clk);
      vid_en = 1'b0; wr_valid = 1'b0;
      checks++;
      if (vid_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL scanout_rvalid: got %b, required 1", vid_rvalid);
      end
      @(negedge clk);
      checks++;
      if (vid_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL scanout_rvalid_drop: got %b, required 0", vid_rvalid);
      end
      $display("test_scanout done");
   endtask

   task automatic test_writer();
      wr_valid = 1'b1; wr_addr = 8'd10; wr_data = 4'hA;
      #1;
      checks++;
      if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 8'd10 || ram_wdata !== 4'hA) begin
         errors++;
         $display("FAIL writer_write: ready=%b we=%b en=%b addr=%0d data=%h, required 1/1/1/10/a",
                  wr_ready, ram_we, ram_en, ram_addr, ram_wdata);
      end
      @(negedge clk);
      wr_addr = 8'd100; wr_data = 4'h3;
      #1;
      checks++;
      if (wr_ready !== 1'b1 || ram_we !== 1'b0 || ram_en !== 1'b0) begin
         errors++;
         $display("FAIL writer_oob: ready=%b we=%b en=%b, required 1/0/0", wr_ready, ram_we, ram_en);
      end
      @(negedge clk);
      wr_addr = 8'd15; wr_data = 4'h7;
      #1;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 8'd15) begin
         errors++;
         $display("FAIL writer_last: we=%b addr=%0d, required 1/15", ram_we, ram_addr);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      $display("test_writer done");
   endtask

   task automatic test_clear();
      int nwr = 0, ndone = 0, last_wr = -1, done_cyc = -1;
      vid_en = 1'b0; wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 4'hC; clr_start = 1'b1;
      #1;
      checks++;
      if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'd3 || ram_wdata !== 4'hC) begin
         errors++;
         $display("FAIL clear_coincident_write: ready=%b we=%b addr=%0d data=%h, required 1/1/3/c",
                  wr_ready, ram_we, ram_addr, ram_wdata);
      end
      @(negedge clk);
      clr_start = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (ram_we) begin
            checks++;
            if (ram_addr !== AW'(nwr) || ram_wdata !== CV) begin
               errors++;
               $display("FAIL clear_write: addr=%0d data=%h, required %0d/%h", ram_addr, ram_wdata, nwr, CV);
            end
            nwr++;
            last_wr = c;
         end
         if (clr_busy) begin
            checks++;
            if (wr_ready !== 1'b0) begin
               errors++;
               $display("FAIL clear_blocks_writer: wr_ready=%b, required 0", wr_ready);
            end
         end
         if (clr_done) begin
            ndone++;
            done_cyc = c;
            wr_valid = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (nwr != DEPTH || ndone != 1 || last_wr != 15 || done_cyc != 16) begin
         errors++;
         $display("FAIL clear_summary: writes=%0d done_pulses=%0d last_wr=%0d done_cyc=%0d, required 16/1/15/16",
                  nwr, ndone, last_wr, done_cyc);
      end
      checks++;
      if (clr_busy !== 1'b0) begin
         errors++;
         $display("FAIL clear_idle: busy=%b, required 0", clr_busy);
      end
      $display("test_clear done");
   endtask

   task automatic test_clear_preempt();
      int nwr = 0, last_wr = -1, done_cyc = -1;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         vid_en = c[0];
         vid_addr = AW'(c);
         #1;
         if (vid_en) begin
            checks++;
            if (ram_we !== 1'b0 || ram_addr !== AW'(c)) begin
               errors++;
               $display("FAIL preempt_read: cyc=%0d we=%b addr=%0d, required 0/%0d", c, ram_we, ram_addr, c);
            end
         end else if (ram_we) begin
            checks++;
            if (ram_addr !== AW'(nwr)) begin
               errors++;
               $display("FAIL preempt_write: cyc=%0d addr=%0d, required %0d", c, ram_addr, nwr);
            end
            nwr++;
            last_wr = c;
         end
         if (clr_done && done_cyc < 0) done_cyc = c;
         @(negedge clk);
      end
      vid_en = 1'b0;
      checks++;
      if (nwr != DEPTH || last_wr != 30 || done_cyc != 31) begin
         errors++;
         $display("FAIL preempt_summary: writes=%0d last_wr=%0d done_cyc=%0d, required 16/30/31",
                  nwr, last_wr, done_cyc);
      end
      $display("test_clear_preempt done");
   endtask

   task automatic test_tear_free();
      t_vblank = 1'b0; t_vid_en = 1'b0; t_wr_valid = 1'b1; t_wr_addr = 8'd7; t_wr_data = 4'h3;
      for (int c = 0; c < 20; c++) begin
         #1;
         checks++;
         if (t_wr_ready !== 1'b0 || t_ram_we !== 1'b0) begin
            errors++;
            $display("FAIL tf_blocked: cyc=%0d ready=%b we=%b, required 0/0", c, t_wr_ready, t_ram_we);
         end
         @(negedge clk);
      end
      checks++;
      if (t_stall_cnt !== 16'd20) begin
         errors++;
         $display("FAIL tf_stall_cnt: got %0d, required 20", t_stall_cnt);
      end
      t_vblank = 1'b1;
      #1;
      checks++;
      if (t_wr_ready !== 1'b1 || t_ram_we !== 1'b1 || t_ram_addr !== 8'd7 || t_ram_wdata !== 4'h3) begin
         errors++;
         $display("FAIL tf_vblank_write: ready=%b we=%b addr=%0d data=%h, required 1/1/7/3",
                  t_wr_ready, t_ram_we, t_ram_addr, t_ram_wdata);
      end
      @(negedge clk);
      t_wr_valid = 1'b0; t_vblank = 1'b0;
      $display("test_tear_free done");
   endtask

   task automatic test_reset_mid_clear();
      int nwr = 0;
      bit hit = 1'b0;
      bit seen_done = 1'b0;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         if (ram_we) begin
            if (nwr == 4) begin
               hit = 1'b1;
               reset = 1'b1;
               #1;
               checks++;
               if (ram_we !== 1'b0 || ram_en !== 1'b0) begin
                  errors++;
                  $display("FAIL abort_gate: we=%b en=%b, required 0/0", ram_we, ram_en);
               end
            end
            nwr++;
         end
         if (!hit) @(negedge clk);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL abort_reach: writes seen=%0d, required 5", nwr);
      end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b, required 0/0", clr_busy, clr_done);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (clr_done || ram_we) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         errors++;
         $display("FAIL abort_quiet: clr_done or ram_we seen after abort, required none");
      end
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      #1;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 8'd0) begin
         errors++;
         $display("FAIL restart_addr: we=%b addr=%0d, required 1/0", ram_we, ram_addr);
      end
      seen_done = 1'b0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         if (clr_done) seen_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (!seen_done) begin
         errors++;
         $display("FAIL restart_done: clr_done not seen within 40 cycles");
      end
      $display("test_reset_mid_clear done");
   endtask

   task automatic test_stall_saturate();
      vid_en = 1'b1; wr_valid = 1'b1; wr_addr = 8'd4;
      repeat (3) @(negedge clk);
      checks++;
      if (stall_cnt !== 16'd3) begin
         errors++;
         $display("FAIL stall_count: got %0d, required 3", stall_cnt);
      end
      force dut.stall_cnt_q = 16'hFFFE;
      #1;
      release dut.stall_cnt_q;
      @(negedge clk);
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL stall_reach_max: got %h, required ffff", stall_cnt);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL stall_saturate: got %h, required ffff", stall_cnt);
      end
      vid_en = 1'b0; wr_valid = 1'b0;
      @(negedge clk);
      $display("test_stall_saturate done");
   endtask

   initial begin
      test_reset();
      test_scanout();
      test_writer();
      test_clear();
      test_clear_preempt();
      test_tear_free();
      test_reset_mid_clear();
      test_stall_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
